// File: rtl/m_port_ultra_point_collector_pkg.sv
// Shared constants and types for the ultra point collector and the hull processor.
package m_port_ultra_pkg;

    // Point-buffer capacity and packed point width (8-bit X in the low byte, 8-bit Y above it)
    localparam int MAXPTS = 256;
    localparam int PTSIZE = 16;
    localparam int CNT_W  = 9;
    localparam int BUF_W  = MAXPTS * PTSIZE;

    // One-hot FSM encodings, shared with the hull processor
    localparam logic [2:0] ST_FILL  = 3'b001;
    localparam logic [2:0] ST_HOLD  = 3'b010;
    localparam logic [2:0] ST_CLEAR = 3'b100;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } point_t;

    // Point count after a beat; the caller never asks to store once the buffer is full
    function automatic logic [CNT_W-1:0] count_after(input logic [CNT_W-1:0] c, input logic store);
        return store ? c + CNT_W'(1) : c;
    endfunction

endpackage

// File: rtl/m_port_ultra_point_collector_if.sv
// Point stream, hull handshake and packed point-set bundle between upstream, collector and hull processor.
interface m_port_ultra_point_collector_if;
    import m_port_ultra_pkg::*;

    logic               pt_valid;
    logic [7:0]         pt_x;
    logic [7:0]         pt_y;
    logic               pt_last;
    logic               pt_ready;
    logic               hull_done;
    logic [BUF_W-1:0]   points;
    logic [CNT_W-1:0]   SS;
    logic               hull_start;
    logic               busy;
    logic               overflow;

    // Environment side: point source plus hull processor
    modport master (
        output pt_valid, pt_x, pt_y, pt_last, hull_done,
        input  pt_ready, points, SS, hull_start, busy, overflow
    );

    // Collector side
    modport slave (
        input  pt_valid, pt_x, pt_y, pt_last, hull_done,
        output pt_ready, points, SS, hull_start, busy, overflow
    );

endinterface

// File: rtl/m_port_ultra_point_collector.sv
// Collects a frame of 2-D points into a packed buffer, then holds it for the hull processor
// until it signals done, and clears the buffer for the next frame.
module m_port_ultra_point_collector
    import m_port_ultra_pkg::*;
(
    input  logic                          CLK100MHZ,
    input  logic                          CPU_RESETN,
    m_port_ultra_point_collector_if.slave bus
);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_ss;
    logic [BUF_W-1:0] r_points;
    point_t           r_last_pt;
    logic             r_last_vld;
    logic             r_hull_start;
    logic             r_ovf;
    logic             r_frame_open;

    logic             w_ready;
    logic             w_acc;
    logic             w_full;
    logic             w_dup;
    logic             w_store;
    logic             w_close;
    logic [CNT_W-1:0] w_new_cnt;
    logic [7:0]       w_idx;

    assign w_ready   = (r_state == ST_FILL);
    assign w_acc     = bus.pt_valid && w_ready;
    assign w_full    = (r_count == CNT_W'(MAXPTS));
    // Only a repeat of the immediately preceding stored point is suppressed
    assign w_dup     = r_last_vld && ({bus.pt_y, bus.pt_x} == r_last_pt);
    assign w_store   = w_acc && !w_full && !w_dup;
    assign w_new_cnt = count_after(r_count, w_store);
    // An empty frame never hands anything to the hull processor
    assign w_close   = w_acc && bus.pt_last && (w_new_cnt != '0);
    assign w_idx     = r_count[7:0];

    // Frame FSM: fill until a non-empty last beat, hold until hull done, one clear cycle
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= ST_FILL;
        end else begin
            case (r_state)
                ST_FILL:  if (w_close) r_state <= ST_HOLD;
                ST_HOLD:  if (bus.hull_done) r_state <= ST_CLEAR;
                ST_CLEAR: r_state <= ST_FILL;
                default:  r_state <= ST_FILL;
            endcase
        end
    end

    // Point buffer, count and last-point tracking
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_points   <= '0;
            r_count    <= '0;
            r_last_pt  <= '0;
            r_last_vld <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_points   <= '0;
            r_count    <= '0;
            r_last_pt  <= '0;
            r_last_vld <= 1'b0;
        end else if (w_store) begin
            r_points[w_idx*PTSIZE +: PTSIZE] <= {bus.pt_y, bus.pt_x};
            r_count    <= w_new_cnt;
            r_last_pt  <= {bus.pt_y, bus.pt_x};
            r_last_vld <= 1'b1;
        end
    end

    // Set size, start pulse and sticky overflow; overflow survives HOLD/CLEAR until the next frame begins
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_ss         <= '0;
            r_hull_start <= 1'b0;
            r_ovf        <= 1'b0;
            r_frame_open <= 1'b0;
        end else begin
            r_hull_start <= w_close;
            if (w_close) begin
                r_ss <= w_new_cnt;
            end else if (r_state == ST_CLEAR) begin
                r_ss <= '0;
            end
            if (w_acc) begin
                r_ovf        <= (r_frame_open && r_ovf) || w_full;
                r_frame_open <= !bus.pt_last;
            end
        end
    end

    assign bus.pt_ready   = w_ready;
    assign bus.points     = r_points;
    assign bus.SS         = r_ss;
    assign bus.hull_start = r_hull_start;
    assign bus.busy       = (r_state == ST_HOLD);
    assign bus.overflow   = r_ovf;

endmodule
